// File: rtl/pulse_swallow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pkg_divider
// Shared definitions for the pulse-swallow divider stage that follows the
// 3/4 dual-modulus prescaler. It holds the default counter width, the
// encodings driven on the prescaler modulus-control input, and the state
// type of the period FSM.
// ---------------------------------------------------------------------------
package pkg_divider;

    // Default width of the P/S counters and of the configuration values.
    localparam int CNT_W_DEF = 8;

    // Modulus-control encodings seen by the prescaler.
    localparam logic MOD_DIV4 = 1'b1;
    localparam logic MOD_DIV3 = 1'b0;

    // IDLE    : no configuration running, outputs quiet.
    // SWALLOW : current prescaler period runs at /4 (mod = 1).
    // MAIN    : current prescaler period runs at /3 (mod = 0).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWALLOW = 2'd1,
        ST_MAIN    = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_swallow_ctrl_if.sv
// ---------------------------------------------------------------------------
// pulse_swallow_ctrl_if
// Configuration and status bundle of the pulse-swallow controller.
//   p_val     : requested program count P          (master -> slave)
//   s_val     : requested swallow count S          (master -> slave)
//   cfg_load  : one-cycle strobe capturing p_val/s_val (master -> slave)
//   mod       : modulus control, 1 = /4, 0 = /3    (slave -> master)
//   div_pulse : one clk_in cycle per output cycle  (slave -> master)
//   cfg_err   : sticky, last cfg_load rejected     (slave -> master)
//   active    : a valid configuration is running   (slave -> master)
// The clock and reset are kept as plain ports of the controller.
// ---------------------------------------------------------------------------
interface pulse_swallow_ctrl_if #(
    parameter int CNT_W = pkg_divider::CNT_W_DEF
) ();

    logic [CNT_W-1:0] p_val;
    logic [CNT_W-1:0] s_val;
    logic             cfg_load;
    logic             mod;
    logic             div_pulse;
    logic             cfg_err;
    logic             active;

    // Host side: programs the divider and watches its status.
    modport master (
        output p_val, s_val, cfg_load,
        input  mod, div_pulse, cfg_err, active
    );

    // Controller side.
    modport slave (
        input  p_val, s_val, cfg_load,
        output mod, div_pulse, cfg_err, active
    );

endinterface

// File: rtl/pulse_swallow_cfg.sv
// ---------------------------------------------------------------------------
// pulse_swallow_cfg
// Validates configuration writes and holds the accepted P/S pair in a shadow
// register until the counter FSM consumes it at a cycle boundary.
//   clk_in        : clock (prescaler output)
//   rst           : synchronous, active-high reset
//   cfg_load_i    : one-cycle write strobe
//   p_val_i       : requested P
//   s_val_i       : requested S
//   shadow_clr_i  : FSM consumed the shadow this cycle
//   shadow_vld_o  : shadow holds a pending configuration
//   shadow_p_o    : pending P
//   shadow_s_o    : pending S
//   cfg_err_o     : sticky, last write was rejected
// A write is accepted when P >= 2 and S <= P.
// ---------------------------------------------------------------------------
module pulse_swallow_cfg
    import pkg_divider::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_load_i,
    input  logic [CNT_W-1:0] p_val_i,
    input  logic [CNT_W-1:0] s_val_i,
    input  logic             shadow_clr_i,
    output logic             shadow_vld_o,
    output logic [CNT_W-1:0] shadow_p_o,
    output logic [CNT_W-1:0] shadow_s_o,
    output logic             cfg_err_o
);

    logic             cfg_ok;
    logic             shadow_vld_d, shadow_vld_q;
    logic             cfg_err_d,    cfg_err_q;
    logic [CNT_W-1:0] shadow_p_d,   shadow_p_q;
    logic [CNT_W-1:0] shadow_s_d,   shadow_s_q;

    assign cfg_ok = (p_val_i >= CNT_W'(2)) && (s_val_i <= p_val_i);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        shadow_vld_d = shadow_vld_q;
        cfg_err_d    = cfg_err_q;
        shadow_p_d   = shadow_p_q;
        shadow_s_d   = shadow_s_q;

        if (shadow_clr_i) begin
            shadow_vld_d = 1'b0;
        end

        // A write landing on the same edge as a consume must survive it,
        // so it is evaluated after the clear.
        if (cfg_load_i) begin
            if (cfg_ok) begin
                shadow_vld_d = 1'b1;
                shadow_p_d   = p_val_i;
                shadow_s_d   = s_val_i;
                cfg_err_d    = 1'b0;
            end else begin
                cfg_err_d    = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            shadow_vld_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            shadow_vld_q <= shadow_vld_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // NOTE: the shadow data carries no reset; it is only ever read while
    // shadow_vld_q is set, and that flag is reset.
    always_ff @(posedge clk_in) begin
        shadow_p_q <= shadow_p_d;
        shadow_s_q <= shadow_s_d;
    end

    assign shadow_vld_o = shadow_vld_q;
    assign shadow_p_o   = shadow_p_q;
    assign shadow_s_o   = shadow_s_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// ---------------------------------------------------------------------------
// pulse_swallow_ctrl
// Program/swallow counter stage behind a 3/4 dual-modulus prescaler. Each
// output cycle spans P prescaler periods: the first S at /4, the remaining
// P-S at /3, for a total division of N = 3P + S input clocks.
//   clk_in : clock, driven by the prescaler output
//   rst    : synchronous, active-high reset
//   bus    : configuration/status bundle (slave side)
//            p_val, s_val, cfg_load in; mod, div_pulse, cfg_err, active out
// New configurations are only taken at a cycle boundary (or out of IDLE), so
// a retune never produces a truncated or stretched output cycle.
// ---------------------------------------------------------------------------
module pulse_swallow_ctrl
    import pkg_divider::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst,
    pulse_swallow_ctrl_if.slave  bus
);

    logic             shadow_vld;
    logic [CNT_W-1:0] shadow_p;
    logic [CNT_W-1:0] shadow_s;
    logic             shadow_clr;
    logic             cfg_err;

    state_e           state_d,     state_q;
    logic [CNT_W-1:0] p_cnt_d,     p_cnt_q;
    logic [CNT_W-1:0] p_act_d,     p_act_q;
    logic [CNT_W-1:0] s_act_d,     s_act_q;
    logic             mod_d,       mod_q;
    logic             div_pulse_d, div_pulse_q;
    logic             running_d;
    logic             last_period;

    pulse_swallow_cfg #(
        .CNT_W (CNT_W)
    ) u_cfg (
        .clk_in       (clk_in),
        .rst          (rst),
        .cfg_load_i   (bus.cfg_load),
        .p_val_i      (bus.p_val),
        .s_val_i      (bus.s_val),
        .shadow_clr_i (shadow_clr),
        .shadow_vld_o (shadow_vld),
        .shadow_p_o   (shadow_p),
        .shadow_s_o   (shadow_s),
        .cfg_err_o    (cfg_err)
    );

    // p_act_q >= 2 whenever running, so the subtraction cannot wrap then.
    assign last_period = (p_cnt_q == p_act_q - CNT_W'(1));

    always_comb begin
        p_cnt_d    = p_cnt_q;
        p_act_d    = p_act_q;
        s_act_d    = s_act_q;
        shadow_clr = 1'b0;
        running_d  = (state_q != ST_IDLE);

        if (state_q == ST_IDLE) begin
            if (shadow_vld) begin
                p_act_d    = shadow_p;
                s_act_d    = shadow_s;
                p_cnt_d    = '0;
                shadow_clr = 1'b1;
                running_d  = 1'b1;
            end
        end else if (last_period) begin
            p_cnt_d = '0;
            if (shadow_vld) begin
                p_act_d    = shadow_p;
                s_act_d    = shadow_s;
                shadow_clr = 1'b1;
            end
        end else begin
            p_cnt_d = p_cnt_q + CNT_W'(1);
        end

        // Outputs are registered, so they are derived from the values the
        // counter and the active config will hold after this edge.
        mod_d       = (running_d && (p_cnt_d < s_act_d)) ? MOD_DIV4 : MOD_DIV3;
        div_pulse_d = running_d && (p_cnt_d == p_act_d - CNT_W'(1));

        if (!running_d) begin
            state_d = ST_IDLE;
        end else if (mod_d == MOD_DIV4) begin
            state_d = ST_SWALLOW;
        end else begin
            state_d = ST_MAIN;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            p_cnt_q     <= '0;
            p_act_q     <= '0;
            s_act_q     <= '0;
            mod_q       <= MOD_DIV3;
            div_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_cnt_q     <= p_cnt_d;
            p_act_q     <= p_act_d;
            s_act_q     <= s_act_d;
            mod_q       <= mod_d;
            div_pulse_q <= div_pulse_d;
        end
    end

    assign bus.mod       = mod_q;
    assign bus.div_pulse = div_pulse_q;
    assign bus.cfg_err   = cfg_err;
    assign bus.active    = (state_q != ST_IDLE);

endmodule
